// File: rtl/compass_pkg.sv
// Shared types and constants for the compass heading calculator.
`timescale 1ns/1ps

package compass_pkg;

  localparam int BAM_W    = 16;
  localparam int DEG_FULL = 360;
  localparam int INT_W    = 19;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ROT,
    ST_SCALE,
    ST_OUT
  } state_t;

  // round(atan(2^-i) * 65536 / (2*pi)), angle in binary angle units
  function automatic logic [BAM_W-1:0] atan_bam(input logic [CNT_W-1:0] i);
    case (i)
      4'd0:    atan_bam = 16'd8192;
      4'd1:    atan_bam = 16'd4836;
      4'd2:    atan_bam = 16'd2555;
      4'd3:    atan_bam = 16'd1297;
      4'd4:    atan_bam = 16'd651;
      4'd5:    atan_bam = 16'd326;
      4'd6:    atan_bam = 16'd163;
      4'd7:    atan_bam = 16'd81;
      4'd8:    atan_bam = 16'd41;
      4'd9:    atan_bam = 16'd20;
      4'd10:   atan_bam = 16'd10;
      4'd11:   atan_bam = 16'd5;
      4'd12:   atan_bam = 16'd3;
      4'd13:   atan_bam = 16'd1;
      4'd14:   atan_bam = 16'd1;
      default: atan_bam = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/compass_bam_to_deg.sv
// Combinational BAM -> integer degree conversion with rounding, 360 wrap
// and declination correction (result always 0..359).
`timescale 1ns/1ps

module compass_bam_to_deg
  import compass_pkg::*;
#(
  parameter int DECL_DEG = 0
) (
  input  logic [BAM_W-1:0] bam,
  output logic [8:0]       deg
);

  localparam logic [24:0]        HALF   = 25'd32768;
  localparam logic signed [10:0] FULL_S = 11'(DEG_FULL);
  localparam logic signed [10:0] DECL_S = 11'(DECL_DEG);

  logic [24:0]        prod;
  logic [8:0]         raw;
  logic [15:0]        frac_unused;
  logic signed [10:0] sum;

  // NOTE: every variable gets a value at the top of the block so no path
  // through it can leave one unassigned and infer a latch.
  always_comb begin
    prod                = 25'(bam) * 25'(DEG_FULL) + HALF;
    {raw, frac_unused}  = prod;
    if (raw == 9'(DEG_FULL)) begin
      raw = '0;
    end
    sum = $signed({2'b00, raw}) + DECL_S;
    if (sum < 0) begin
      sum = sum + FULL_S;
    end else if (sum >= FULL_S) begin
      sum = sum - FULL_S;
    end
    deg = sum[8:0];
  end

endmodule

// File: rtl/compass_heading_calc.sv
// Magnetic heading from X/Y field samples via iterative vectoring CORDIC.
// Optional hard-iron calibration is enabled with `define HARD_IRON_CAL_EN.
`timescale 1ns/1ps

module compass_heading_calc
  import compass_pkg::*;
#(
  parameter int ITER     = 14,
  parameter int DECL_DEG = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] mag_x,
  input  logic signed [15:0] mag_y,
  input  logic               cal_clear,
  output logic               busy,
  output logic               heading_valid,
  output logic [8:0]         heading_deg,
  output logic               zero_vec,
  output logic               overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t state, next_state;

  logic signed [INT_W-1:0] x, y;
  logic signed [INT_W-1:0] x_adj, y_adj;
  logic signed [INT_W-1:0] x_sh, y_sh;
  logic [BAM_W-1:0]        z, z_scale;
  logic [CNT_W-1:0]        cnt;
  logic                    zero_r;
  logic [8:0]              deg_w, deg_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (in_valid) next_state = ST_PRE;
      ST_PRE:   next_state = ST_ROT;
      ST_ROT:   if (cnt == CNT_LAST) next_state = ST_SCALE;
      ST_SCALE: next_state = ST_OUT;
      ST_OUT:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state != ST_IDLE);
  end

`ifdef HARD_IRON_CAL_EN
  logic signed [15:0] min_x, max_x, min_y, max_y;
  logic signed [15:0] off_x, off_y;
  logic signed [15:0] raw_x, raw_y;
  logic signed [15:0] nmin_x, nmax_x, nmin_y, nmax_y;
  logic signed [16:0] sum_x, sum_y;

  // In PRE, x/y still hold the sign-extended raw sample.
  assign raw_x  = x[15:0];
  assign raw_y  = y[15:0];
  assign nmin_x = (raw_x < min_x) ? raw_x : min_x;
  assign nmax_x = (raw_x > max_x) ? raw_x : max_x;
  assign nmin_y = (raw_y < min_y) ? raw_y : min_y;
  assign nmax_y = (raw_y > max_y) ? raw_y : max_y;
  assign sum_x  = {nmax_x[15], nmax_x} + {nmin_x[15], nmin_x};
  assign sum_y  = {nmax_y[15], nmax_y} + {nmin_y[15], nmin_y};

  // Offsets registered before this sample are applied; the update lands after.
  assign x_adj = x - {{(INT_W-16){off_x[15]}}, off_x};
  assign y_adj = y - {{(INT_W-16){off_y[15]}}, off_y};

  always_ff @(posedge clk) begin
    if (rst || cal_clear) begin
      min_x <= 16'sh7fff;
      max_x <= 16'sh8000;
      min_y <= 16'sh7fff;
      max_y <= 16'sh8000;
      off_x <= '0;
      off_y <= '0;
    end else if (state == ST_PRE) begin
      min_x <= nmin_x;
      max_x <= nmax_x;
      min_y <= nmin_y;
      max_y <= nmax_y;
      off_x <= sum_x[16:1];
      off_y <= sum_y[16:1];
    end
  end
`else
  logic cal_unused;

  assign cal_unused = cal_clear;
  assign x_adj      = x;
  assign y_adj      = y;
`endif

  assign x_sh    = x >>> cnt;
  assign y_sh    = y >>> cnt;
  assign z_scale = zero_r ? '0 : z;

  compass_bam_to_deg #(
    .DECL_DEG (DECL_DEG)
  ) u_bam_to_deg (
    .bam (z_scale),
    .deg (deg_w)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what the CORDIC step relies on.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset so an aborted sample leaves
    // no stale result that could be presented later.
    if (rst) begin
      x             <= '0;
      y             <= '0;
      z             <= '0;
      cnt           <= '0;
      zero_r        <= 1'b0;
      deg_r         <= '0;
      heading_deg   <= '0;
      heading_valid <= 1'b0;
      zero_vec      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      heading_valid <= 1'b0;
      overrun       <= in_valid && busy;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x      <= {{(INT_W-16){mag_x[15]}}, mag_x};
            y      <= {{(INT_W-16){mag_y[15]}}, mag_y};
            zero_r <= (mag_x == 16'sd0) && (mag_y == 16'sd0);
            cnt    <= '0;
          end
        end
        ST_PRE: begin
          // Fold the left half-plane onto the right so CORDIC converges.
          if (x_adj < 0) begin
            x <= -x_adj;
            y <= -y_adj;
            z <= 16'h8000;
          end else begin
            x <= x_adj;
            y <= y_adj;
            z <= '0;
          end
          cnt <= '0;
        end
        ST_ROT: begin
          if (!y[INT_W-1]) begin
            x <= x + y_sh;
            y <= y - x_sh;
            z <= z + atan_bam(cnt);
          end else begin
            x <= x - y_sh;
            y <= y + x_sh;
            z <= z - atan_bam(cnt);
          end
          cnt <= cnt + 1'b1;
        end
        ST_SCALE: begin
          deg_r <= deg_w;
        end
        ST_OUT: begin
          heading_deg   <= deg_r;
          zero_vec      <= zero_r;
          heading_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compass_heading_calc.sv
// Scoreboard bench for compass_heading_calc: a default instance and a
// DECL_DEG=-10 instance share stimulus; expectations come from $atan2.
`timescale 1ns/1ps

module tb_compass_heading_calc;

  localparam int  ITER   = 14;
  localparam int  DECL_B = -10;
  localparam real PI     = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               cal_clear = 1'b0;
  logic signed [15:0] mag_x = '0;
  logic signed [15:0] mag_y = '0;

  logic       busy_a, valid_a, zero_a, ovr_a;
  logic [8:0] deg_a;
  logic       busy_b, valid_b, zero_b, ovr_b;
  logic [8:0] deg_b;

  compass_heading_calc #(.ITER(ITER), .DECL_DEG(0)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .mag_x         (mag_x),
    .mag_y         (mag_y),
    .cal_clear     (cal_clear),
    .busy          (busy_a),
    .heading_valid (valid_a),
    .heading_deg   (deg_a),
    .zero_vec      (zero_a),
    .overrun       (ovr_a)
  );

  compass_heading_calc #(.ITER(ITER), .DECL_DEG(DECL_B)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .mag_x         (mag_x),
    .mag_y         (mag_y),
    .cal_clear     (cal_clear),
    .busy          (busy_b),
    .heading_valid (valid_b),
    .heading_deg   (deg_b),
    .zero_vec      (zero_b),
    .overrun       (ovr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int exp_deg;
    int tol;
    bit zero;
    int issue;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // tol > 0 means an angular comparison with wrap-around at 360
  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    int d;
    checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (tol > 0 && (360 - d) < d) d = 360 - d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc);
    end
  endtask

  function automatic int wrap360(input int v);
    return ((v % 360) + 360) % 360;
  endfunction

  function automatic int ref_deg(input int x, input int y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x)) * 180.0 / PI;
    if (a < 0.0) a = a + 360.0;
    return wrap360($rtoi(a + 0.5));
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  task automatic push(input int e, input int tol, input bit z);
    exp_t ea;
    exp_t eb;
    ea.exp_deg = e;
    ea.tol     = tol;
    ea.zero    = z;
    ea.issue   = cyc + 1;
    eb         = ea;
    eb.exp_deg = wrap360(e + DECL_B);
    sb_a.push_back(ea);
    sb_b.push_back(eb);
  endtask

  task automatic drive(input int x, input int y, input bit do_push, input int e, input int tol);
    @(negedge clk);
    in_valid = 1'b1;
    mag_x    = 16'(x);
    mag_y    = 16'(y);
    if (do_push) push(e, tol, (x == 0 && y == 0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    cal_clear = 1'b1;
    @(negedge clk);
    cal_clear = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      check("drain_timeout", sb_a.size() + sb_b.size(), 0);
      sb_a.delete();
      sb_b.delete();
    end
  endtask

  task automatic sample(input int x, input int y, input int tol);
    pulse_clear();
    drive(x, y, 1'b1, ref_deg(x, y), tol);
    drain(40);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (valid_a) begin
      if (sb_a.size() == 0) begin
        check("a_spurious_valid", 1, 0);
      end else begin
        e = sb_a.pop_front();
        check("a_deg", int'(deg_a), e.exp_deg, e.tol);
        check("a_range", int'(deg_a < 9'd360), 1);
        check("a_zero_vec", int'(zero_a), int'(e.zero));
        check("a_latency", cyc - e.issue, ITER + 3);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (valid_b) begin
      if (sb_b.size() == 0) begin
        check("b_spurious_valid", 1, 0);
      end else begin
        e = sb_b.pop_front();
        check("b_deg", int'(deg_b), e.exp_deg, e.tol);
        check("b_range", int'(deg_b < 9'd360), 1);
        check("b_zero_vec", int'(zero_b), int'(e.zero));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_deg", int'(deg_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_zero_vec", int'(zero_a), 0);
    check("rst_overrun", int'(ovr_a), 0);
    check("rst_b_deg", int'(deg_b), 0);
    rst = 1'b0;

    // Directed points; the exact ones get zero tolerance
    sample(1000, 0, 0);
    sample(0, 1000, 1);
    sample(-1000, 0, 1);
    sample(0, -1000, 1);
    sample(1000, 1000, 1);
    sample(-32768, -32768, 1);
    sample(30000, -50, 0);
    sample(0, 0, 0);

    // Full circle at radius 20000
    for (int a = 0; a < 360; a++) begin
      real r;
      r = real'(a) * PI / 180.0;
      sample(rnd(20000.0 * $cos(r)), rnd(20000.0 * $sin(r)), 1);
    end

    // Second strobe five cycles after the first is dropped
    pulse_clear();
    drive(-1000, 0, 1'b1, 180, 1);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    mag_x    = 16'sd0;
    mag_y    = 16'sd1000;
    check("ovr_before", int'(ovr_a), 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovr_pulse_a", int'(ovr_a), 1);
    check("ovr_pulse_b", int'(ovr_b), 1);
    @(negedge clk);
    check("ovr_single", int'(ovr_a), 0);
    drain(40);

    // Reset mid-computation: the sample never produces a heading
    drive(1000, 1000, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    check("abort_busy_before", int'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_a", int'(busy_a), 0);
    check("abort_busy_b", int'(busy_b), 0);
    check("abort_valid", int'(valid_a), 0);
    repeat (25) @(negedge clk);
    check("abort_idle", int'(busy_a), 0);

`ifdef HARD_IRON_CAL_EN
    pulse_clear();
    drive(1100, 100, 1'b1, 5, 0);
    drain(40);
    drive(-900, 100, 1'b1, 180, 1);
    drain(40);
    drive(100, 1100, 1'b1, 90, 1);
    drain(40);
    drive(100, -900, 1'b1, 270, 1);
    drain(40);
    drive(1100, 100, 1'b1, 0, 0);
    drain(40);
    pulse_clear();
    drive(1100, 100, 1'b1, 5, 0);
    drain(40);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
